// File: rtl/dac_share_arbiter.sv
// Two-source arbiter that shares one SPI DAC writer: latches one pending sample per source and
// sequences start/busy/done plus a minimum inter-frame gap. `DAC_ARB_FIXED_PRIO_EN selects fixed priority.
module dac_share_arbiter #(
  parameter int GAP_CYCLES   = 8,
  parameter int BUSY_TIMEOUT = 64,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_i,
  input  logic [15:0]      data0_i,
  input  logic             req1_i,
  input  logic [15:0]      data1_i,
  input  logic [1:0]       enable_i,
  input  logic             dac_busy_i,
  output logic             dac_start_o,
  output logic [15:0]      dac_data_o,
  output logic             dac_chan_o,
  output logic [1:0]       grant_o,
  output logic [CNT_W-1:0] drop0_o,
  output logic [CNT_W-1:0] drop1_o,
  output logic             timeout_o
);

  localparam int TMR_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(BUSY_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        req_vec;
  logic [15:0]       data_vec [2];
  logic [1:0]        pend_reg;
  logic [15:0]       smp_reg [2];
  logic [CNT_W-1:0]  drop_reg [2];
  logic [1:0]        take;
  logic              win;
  logic [15:0]       data_reg, data_next;
  logic              chan_reg, chan_next;
  logic              start_reg, start_next;
  logic [1:0]        grant_reg, grant_next;
  logic [TMR_W-1:0]  timer_reg, timer_next;
  logic [GAP_W-1:0]  gap_reg, gap_next;
  logic              timeout_reg, timeout_next;
`ifndef DAC_ARB_FIXED_PRIO_EN
  logic              last_reg, last_next;
`endif

  assign req_vec     = {req1_i, req0_i};
  assign data_vec[0] = data0_i;
  assign data_vec[1] = data1_i;

  // A request arriving while the same source is being granted refills the slot without a drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_reg <= '0;
      for (int i = 0; i < 2; i++) begin
        smp_reg[i]  <= '0;
        drop_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!enable_i[i]) begin
          pend_reg[i] <= 1'b0;
        end else if (req_vec[i]) begin
          smp_reg[i]  <= data_vec[i];
          pend_reg[i] <= 1'b1;
          if (pend_reg[i] && !take[i] && (drop_reg[i] != '1))
            drop_reg[i] <= drop_reg[i] + CNT_W'(1);
        end else if (take[i]) begin
          pend_reg[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      data_reg    <= '0;
      chan_reg    <= 1'b0;
      start_reg   <= 1'b0;
      grant_reg   <= '0;
      timer_reg   <= '0;
      gap_reg     <= '0;
      timeout_reg <= 1'b0;
`ifndef DAC_ARB_FIXED_PRIO_EN
      last_reg    <= 1'b1;
`endif
    end else begin
      state_reg   <= state_next;
      data_reg    <= data_next;
      chan_reg    <= chan_next;
      start_reg   <= start_next;
      grant_reg   <= grant_next;
      timer_reg   <= timer_next;
      gap_reg     <= gap_next;
      timeout_reg <= timeout_next;
`ifndef DAC_ARB_FIXED_PRIO_EN
      last_reg    <= last_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    data_next    = data_reg;
    chan_next    = chan_reg;
    start_next   = 1'b0;
    grant_next   = 2'b00;
    timer_next   = timer_reg;
    gap_next     = gap_reg;
    timeout_next = timeout_reg;
    take         = 2'b00;
    win          = 1'b0;
`ifndef DAC_ARB_FIXED_PRIO_EN
    last_next    = last_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (|pend_reg) begin
`ifdef DAC_ARB_FIXED_PRIO_EN
          win = ~pend_reg[0];
`else
          win       = (&pend_reg) ? ~last_reg : pend_reg[1];
          last_next = win;
`endif
          take       = win ? 2'b10 : 2'b01;
          data_next  = smp_reg[win];
          chan_next  = win;
          start_next = 1'b1;
          grant_next = take;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        timer_next = '0;
        state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (dac_busy_i) begin
          state_next = WAIT_DONE;
        end else if (timer_reg == TMR_LAST) begin
          timeout_next = 1'b1;
          gap_next     = '0;
          state_next   = GAP;
        end else begin
          timer_next = timer_reg + TMR_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!dac_busy_i) begin
          gap_next   = '0;
          state_next = GAP;
        end
      end
      GAP: begin
        if (gap_reg == GAP_LAST) state_next = IDLE;
        else                     gap_next   = gap_reg + GAP_W'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  assign dac_start_o = start_reg;
  assign dac_data_o  = data_reg;
  assign dac_chan_o  = chan_reg;
  assign grant_o     = grant_reg;
  assign drop0_o     = drop_reg[0];
  assign drop1_o     = drop_reg[1];
  assign timeout_o   = timeout_reg;

endmodule

// File: tb/tb_dac_share_arbiter.sv
// Directed bench for dac_share_arbiter: a cycle table for the basic frame plus hand-written
// sequences for arbitration, overwrite counting, timeout and reset.
module tb_dac_share_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, busy;
  logic [15:0] data0, data1;
  logic [1:0]  enable;
  logic        dac_start_o, dac_chan_o, timeout_o;
  logic [15:0] dac_data_o;
  logic [1:0]  grant_o;
  logic [7:0]  drop0_o, drop1_o;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  dac_share_arbiter #(.GAP_CYCLES(8), .BUSY_TIMEOUT(64), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .req0_i(req0), .data0_i(data0), .req1_i(req1), .data1_i(data1),
    .enable_i(enable), .dac_busy_i(busy),
    .dac_start_o(dac_start_o), .dac_data_o(dac_data_o), .dac_chan_o(dac_chan_o),
    .grant_o(grant_o), .drop0_o(drop0_o), .drop1_o(drop1_o), .timeout_o(timeout_o)
  );

  typedef struct {
    logic        r0;
    logic [15:0] d0;
    logic        busy;
    logic        e_start;
    logic [15:0] e_data;
    logic [1:0]  e_grant;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input logic r0, input logic [15:0] d0, input logic b,
                              input logic st, input logic [15:0] dat, input logic [1:0] gr);
    vec_t v;
    v.r0 = r0; v.d0 = d0; v.busy = b; v.e_start = st; v.e_data = dat; v.e_grant = gr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic [15:0] d0, input logic r1, input logic [15:0] d1);
    req0 = r0; data0 = d0; req1 = r1; data1 = d1;
    tick();
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic wait_start(input int bound);
    int n = 0;
    while (dac_start_o !== 1'b1 && n < bound) begin
      tick();
      n++;
    end
    check("start_seen", 32'(dac_start_o), 32'd1);
    $display("frame: chan=%0d data=0x%04h grant=%b after %0d cycles", dac_chan_o, dac_data_o, grant_o, n);
  endtask

  task automatic serve_frame();
    tick();
    tick();
    busy = 1'b1;
    repeat (3) tick();
    busy = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; busy = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_start"},   32'(dac_start_o), 32'd0);
    check({tag, "_data"},    32'(dac_data_o),  32'd0);
    check({tag, "_chan"},    32'(dac_chan_o),  32'd0);
    check({tag, "_grant"},   32'(grant_o),     32'd0);
    check({tag, "_drop0"},   32'(drop0_o),     32'd0);
    check({tag, "_drop1"},   32'(drop1_o),     32'd0);
    check({tag, "_timeout"}, 32'(timeout_o),   32'd0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  exp_chan;
    logic [15:0] exp_data;
    int          seen;

    enable = 2'b11; data0 = '0; data1 = '0;
    reset = 1'b1; busy = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    check_zero("reset");
    reset = 1'b0;

    // Single frame: req row 1, start after row 2, busy falls at row 8, next start at row 17.
    tbl[0] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 2'b00);
    tbl[1] = mk(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 2'b00);
    tbl[2] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 2'b01);
    tbl[3] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 2'b00);
    tbl[4] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 2'b00);
    tbl[5] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 2'b00);
    tbl[6] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 2'b00);
    tbl[7] = mk(1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h1234, 2'b00);
    for (int i = 8; i < 17; i++) tbl[i] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 2'b00);
    tbl[17] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 2'b01);

    for (int i = 0; i < 18; i++) begin
      req0 = tbl[i].r0; data0 = tbl[i].d0; busy = tbl[i].busy;
      tick();
      req0 = 1'b0;
      check($sformatf("vec%0d_start", i), 32'(dac_start_o), 32'(tbl[i].e_start));
      check($sformatf("vec%0d_data", i),  32'(dac_data_o),  32'(tbl[i].e_data));
      check($sformatf("vec%0d_grant", i), 32'(grant_o),     32'(tbl[i].e_grant));
      check($sformatf("vec%0d_chan", i),  32'(dac_chan_o),  32'd0);
      check($sformatf("vec%0d_drop0", i), 32'(drop0_o),     32'd0);
    end
    serve_frame();

    // Tied requests every frame.
    do_reset();
    drive(1'b1, 16'hAAAA, 1'b1, 16'h5555);
    for (int f = 0; f < 4; f++) begin
      wait_start(40);
`ifdef DAC_ARB_FIXED_PRIO_EN
      exp_chan = 2'd0;
`else
      exp_chan = 2'(f % 2);
`endif
      exp_data = (exp_chan == 2'd0) ? 16'hAAAA : 16'h5555;
      check($sformatf("tie%0d_chan", f),  32'(dac_chan_o), 32'(exp_chan[0]));
      check($sformatf("tie%0d_grant", f), 32'(grant_o),    (exp_chan == 2'd0) ? 32'd1 : 32'd2);
      check($sformatf("tie%0d_data", f),  32'(dac_data_o), 32'(exp_data));
      drive(1'b1, 16'hAAAA, 1'b1, 16'h5555);
      serve_frame();
    end

    // Overwrites while a frame is in flight.
    do_reset();
    drive(1'b0, 16'h0000, 1'b1, 16'h0777);
    wait_start(10);
    check("ovw_first_data", 32'(dac_data_o), 32'h0777);
    drive(1'b1, 16'h0001, 1'b0, 16'h0000);
    drive(1'b1, 16'h0002, 1'b0, 16'h0000);
    drive(1'b1, 16'h0003, 1'b0, 16'h0000);
    serve_frame();
    wait_start(40);
    check("ovw_data",  32'(dac_data_o), 32'h0003);
    check("ovw_chan",  32'(dac_chan_o), 32'd0);
    check("ovw_drop0", 32'(drop0_o),    32'd2);
    check("ovw_drop1", 32'(drop1_o),    32'd0);
    serve_frame();
    for (int i = 0; i < 300; i++) drive(1'b1, 16'(i), 1'b0, 16'h0000);
    check("sat_drop0", 32'(drop0_o), 32'd255);

    // Request arriving in the same cycle its pending sample is granted.
    do_reset();
    drive(1'b0, 16'h0000, 1'b1, 16'h1111);
    drive(1'b0, 16'h0000, 1'b1, 16'h2222);
    check("same_start", 32'(dac_start_o), 32'd1);
    check("same_old_data", 32'(dac_data_o), 32'h1111);
    check("same_drop1", 32'(drop1_o), 32'd0);
    serve_frame();
    wait_start(40);
    check("same_new_data", 32'(dac_data_o), 32'h2222);
    check("same_new_chan", 32'(dac_chan_o), 32'd1);
    check("same_drop1_after", 32'(drop1_o), 32'd0);
    serve_frame();

    // Busy never rises.
    do_reset();
    drive(1'b1, 16'h0ABC, 1'b0, 16'h0000);
    wait_start(10);
    check("to_first_data", 32'(dac_data_o), 32'h0ABC);
    for (int i = 0; i < 64; i++) begin
      req1 = (i == 5); data1 = 16'h0DEF;
      tick();
      req1 = 1'b0;
    end
    check("timeout_early", 32'(timeout_o), 32'd0);
    tick();
    check("timeout_set", 32'(timeout_o), 32'd1);
    wait_start(40);
    check("to_resume_data",  32'(dac_data_o), 32'h0DEF);
    check("to_resume_grant", 32'(grant_o),    32'd2);
    serve_frame();
    check("timeout_sticky", 32'(timeout_o), 32'd1);

    // Reset in WAIT_DONE with both sources pending.
    do_reset();
    drive(1'b1, 16'h0101, 1'b0, 16'h0000);
    wait_start(10);
    tick();
    busy = 1'b1;
    tick();
    tick();
    drive(1'b1, 16'h0202, 1'b1, 16'h0303);
    reset = 1'b1; busy = 1'b0;
    tick();
    check_zero("midreset");
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (dac_start_o === 1'b1) seen++;
    end
    check("no_start_after_reset", 32'(seen), 32'd0);

    enable = 2'b01;
    drive(1'b0, 16'h0000, 1'b1, 16'h0999);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dac_start_o === 1'b1) seen++;
    end
    check("disabled_req1_ignored", 32'(seen), 32'd0);
    drive(1'b1, 16'h0404, 1'b0, 16'h0000);
    wait_start(10);
    check("en_data",  32'(dac_data_o), 32'h0404);
    check("en_chan",  32'(dac_chan_o), 32'd0);
    check("en_drop1", 32'(drop1_o),    32'd0);
    serve_frame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
